// File: rtl/input_conditioner.sv
// Multi-channel pin conditioner: optional inversion, synchronizer, per-channel
// CE-throttled debounce filter, and registered rise/fall/any-edge pulses.
module input_conditioner #(
   parameter int              N_CH            = 3,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = 16,
   parameter logic [N_CH-1:0] DEBOUNCE_EN     = '1,
   parameter logic [N_CH-1:0] INVERT          = '0,
   parameter logic [N_CH-1:0] RESET_VAL       = '0
) (
   input  logic            CLK_DRV,
   input  logic            RESET,
   input  logic            CE,
   input  logic [N_CH-1:0] IN,
   output logic [N_CH-1:0] OUT,
   output logic [N_CH-1:0] RISE,
   output logic [N_CH-1:0] FALL,
   output logic            ANY_EDGE
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

   logic [N_CH-1:0] sync_last;
   logic [N_CH-1:0] out_next;
   logic [N_CH-1:0] out_reg;
   logic [N_CH-1:0] rise_reg;
   logic [N_CH-1:0] fall_reg;
   logic            any_reg;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_reg;

         // Inversion happens ahead of the first flop so the whole chain sees the
         // logical level and RESET_VAL is expressed in that same sense.
         always_ff @(posedge CLK_DRV or posedge RESET) begin
            if (RESET) begin
               sync_reg <= {SYNC_STAGES{RESET_VAL[gi]}};
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], IN[gi] ^ INVERT[gi]};
            end
         end

         assign sync_last[gi] = sync_reg[SYNC_STAGES-1];

         if (DEBOUNCE_EN[gi] && (DEBOUNCE_CYCLES > 0)) begin : g_filt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             out_ch_next;

            // Any agreement with the current output discards progress; CE low
            // only freezes the count while a mismatch persists.
            always_comb begin
               cnt_next    = cnt_reg;
               out_ch_next = out_reg[gi];
               if (sync_last[gi] == out_reg[gi]) begin
                  cnt_next = '0;
               end else if (CE) begin
                  if (cnt_reg == CNT_LAST) begin
                     out_ch_next = sync_last[gi];
                     cnt_next    = '0;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end

            always_ff @(posedge CLK_DRV or posedge RESET) begin
               if (RESET) begin
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_next;
               end
            end

            assign out_next[gi] = out_ch_next;
         end else begin : g_bypass
            assign out_next[gi] = sync_last[gi];
         end
      end
   endgenerate

   // Pulses come from the next-state terms so they line up with the first
   // cycle OUT shows its new level.
   always_ff @(posedge CLK_DRV or posedge RESET) begin
      if (RESET) begin
         out_reg  <= RESET_VAL;
         rise_reg <= '0;
         fall_reg <= '0;
         any_reg  <= 1'b0;
      end else begin
         out_reg  <= out_next;
         rise_reg <= out_next & ~out_reg;
         fall_reg <= ~out_next & out_reg;
         any_reg  <= |(out_next ^ out_reg);
      end
   end

   assign OUT      = out_reg;
   assign RISE     = rise_reg;
   assign FALL     = fall_reg;
   assign ANY_EDGE = any_reg;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioning block between the board pins (coin switch, paddle comparator outputs, DIP switches) and the PONG core. It replaces per-signal synchronizers in the board top. Each channel gets:

- optional polarity inversion;
- a configurable-depth synchronizer;
- a per-channel debounce filter with clock-enable throttling;
- registered one-cycle rise/fall pulses.

## Interface

Parameters:

- N_CH, 3: number of channels (≥1).
- SYNC_STAGES, 2: synchronizer flop count per channel (≥2).
- DEBOUNCE_CYCLES, 16: consecutive CE-qualified mismatch cycles required before a debounced output changes. 0 means all channels bypass the debounce filter.
- DEBOUNCE_EN, all ones (N_CH bits): per-channel debounce enable. A 0 bit bypasses the filter for that channel.
- INVERT, all zeros (N_CH bits): per-channel inversion applied to the pin before the first synchronizer flop.
- RESET_VAL, all zeros (N_CH bits): value loaded into the synchronizer chain and the output register at reset.

Ports:

- CLK_DRV  in  1  drive clock, 14.318 MHz; all state on its rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- CE  in  1  debounce count enable. Synchronizers and bypass channels ignore it.
- IN  in  N_CH  raw asynchronous pin inputs.
- OUT  out  N_CH  conditioned level.
- RISE  out  N_CH  one-cycle pulse on an OUT 0→1 transition.
- FALL  out  N_CH  one-cycle pulse on an OUT 1→0 transition.
- ANY_EDGE  out  1  registered OR of all RISE|FALL bits, same cycle as those bits.

## Operation

Per channel i, the signals are:

- x = IN[i] ^ INVERT[i].
- sync = last stage of an SYNC_STAGES-deep flop chain clocked every CLK_DRV edge.
- Counter cnt, width max(1, $clog2(DEBOUNCE_CYCLES+1)).

Filtered channel (DEBOUNCE_EN[i]=1 and DEBOUNCE_CYCLES>0), evaluated every edge:

- sync == OUT[i]: cnt ← 0, regardless of CE.
- sync != OUT[i] and CE=0: cnt holds.
- sync != OUT[i], CE=1, cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
- sync != OUT[i], CE=1, cnt == DEBOUNCE_CYCLES-1: OUT[i] ← sync, cnt ← 0.

Bypass channel:

- OUT[i] ← sync every edge.
- cnt is held at 0.
- CE has no effect.

Edge outputs:

- RISE[i] ← (next OUT[i]=1) & (OUT[i]=0), registered. It is high exactly in the first cycle OUT[i] shows 1.
- FALL[i] is the mirror of RISE[i].
- ANY_EDGE is registered from the same next-state terms.

The channels are fully independent. Simultaneous transitions on several channels each produce their own pulses, and ANY_EDGE is a single cycle high.

Reset behaviour:

- On reset: synchronizer stages ← RESET_VAL ^ 0, OUT ← RESET_VAL, cnt ← 0, RISE = FALL = ANY_EDGE = 0.
- Reset applies immediately on assertion, including mid-count.
- No pulses are generated by reset entry or exit.

## Timing

- Filtered latency, clean step, CE held 1: OUT changes SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge that samples the new IN level.
- Bypass latency: SYNC_STAGES + 1 edges.
- A filtered channel's input must be stable for DEBOUNCE_CYCLES consecutive CE cycles at sync. Any return to the OUT value clears the progress.
- A pulse of ≤ DEBOUNCE_CYCLES-1 CE cycles never reaches OUT.
- CE low stretches the filter window; mismatch progress is kept while CE is low.
- RISE/FALL/ANY_EDGE are single-cycle. There is no back-to-back toggling on filtered channels faster than DEBOUNCE_CYCLES CE cycles.
- A bypass channel can produce RISE and FALL on consecutive cycles.
- First edge after RESET release: state is exactly the reset values. Counting begins on that edge if sync != OUT.

## Test plan

Common settings: N_CH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, DEBOUNCE_EN=3'b101, INVERT=3'b100, RESET_VAL=3'b010, CE=1 unless stated.

- Reset, IN=3'b000 held: OUT=3'b010 immediately. RISE/FALL/ANY_EDGE stay 0 for the reset duration and the first edge after release. OUT[2] rises 18 edges after release with RISE[2] high for one cycle.
- Clean step: IN[0] 0→1 at edge k → OUT[0]=1 from edge k+18. RISE[0] and ANY_EDGE high only at edge k+18. FALL stays 0.
- Glitch rejection: IN[0] high 15 cycles, then low 1 cycle, then high 20 cycles → OUT[0] changes only at 18 edges after the final rising step. No pulses before that.
- CE throttling: CE high every 4th cycle, IN[0] stepped and held → OUT[0] changes after 2 + 16 CE-qualified edges, ~66 edges. Progress is not lost when CE is low.
- Bypass channel 1: a one-cycle high pulse on IN[1] → OUT[1] reproduces a one-cycle high 3 edges later. RISE[1] and FALL[1] fire on consecutive cycles, ANY_EDGE high for both.
- Mid-count reset: step IN[0], assert RESET after 10 edges → OUT=3'b010 and cnt=0 asynchronously. After release, the full 18-edge latency is required again.
